// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate generator: decodes the I/S/B/U/J/zimm/shamt
// immediate and carries it with a sideband tag through PIPE_DEPTH elastic stages.
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter int PIPE_DEPTH = 1,
  parameter int TAG_W      = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INSTRUCTION,
  input  logic [2:0]       IMM_SEL,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  IMMEDIATE,
  output logic             ILLEGAL,
  output logic [TAG_W-1:0] OUT_TAG
);

  typedef enum logic [2:0] {
    SEL_I     = 3'd0,
    SEL_S     = 3'd1,
    SEL_B     = 3'd2,
    SEL_U     = 3'd3,
    SEL_J     = 3'd4,
    SEL_Z     = 3'd5,
    SEL_SHAMT = 3'd6,
    SEL_NONE  = 3'd7
  } imm_sel_e;

  localparam int LAST = PIPE_DEPTH - 1;

  imm_sel_e        sel;
  logic            sign;
  logic [XLEN-1:0] imm_c;
  logic            illegal_c;
  logic            unused_bits;

  assign sel         = imm_sel_e'(IMM_SEL);
  assign sign        = INSTRUCTION[31];
  // Opcode bits never feed an immediate.
  assign unused_bits = ^INSTRUCTION[6:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    imm_c     = '0;
    illegal_c = 1'b0;
    case (sel)
      SEL_I:     imm_c = {{(XLEN-11){sign}}, INSTRUCTION[30:20]};
      SEL_S:     imm_c = {{(XLEN-11){sign}}, INSTRUCTION[30:25], INSTRUCTION[11:7]};
      SEL_B:     imm_c = {{(XLEN-12){sign}}, INSTRUCTION[7], INSTRUCTION[30:25],
                          INSTRUCTION[11:8], 1'b0};
      SEL_U:     imm_c = {{(XLEN-31){sign}}, INSTRUCTION[30:12], 12'h000};
      SEL_J:     imm_c = {{(XLEN-20){sign}}, INSTRUCTION[19:12], INSTRUCTION[20],
                          INSTRUCTION[30:21], 1'b0};
      SEL_Z:     imm_c = {{(XLEN-5){1'b0}}, INSTRUCTION[19:15]};
      SEL_SHAMT: begin
        if (XLEN == 32) begin
          imm_c     = {{(XLEN-5){1'b0}}, INSTRUCTION[24:20]};
          illegal_c = INSTRUCTION[25];
        end else begin
          imm_c     = {{(XLEN-6){1'b0}}, INSTRUCTION[25:20]};
        end
      end
      SEL_NONE:  imm_c = '0;
    endcase
  end

  logic [PIPE_DEPTH-1:0] valid_q;
  logic [XLEN-1:0]       imm_q   [PIPE_DEPTH];
  logic                  ill_q   [PIPE_DEPTH];
  logic [TAG_W-1:0]      tag_q   [PIPE_DEPTH];

  logic [PIPE_DEPTH-1:0] valid_d;
  logic [XLEN-1:0]       imm_d   [PIPE_DEPTH];
  logic                  ill_d   [PIPE_DEPTH];
  logic [TAG_W-1:0]      tag_d   [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] accept;

  // A stage can take a new entry when it is empty or its occupant moves on;
  // the chain is evaluated from the output back so a pop frees the whole pipe.
  always_comb begin
    logic chain;
    accept = '0;
    chain  = !valid_q[LAST] || OUT_READY;
    accept[LAST] = chain;
    for (int k = LAST - 1; k >= 0; k--) begin
      chain     = !valid_q[k] || chain;
      accept[k] = chain;
    end
  end

  always_comb begin
    valid_d    = '0;
    valid_d[0] = IN_VALID;
    imm_d[0]   = imm_c;
    ill_d[0]   = illegal_c;
    tag_d[0]   = IN_TAG;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      imm_d[k]   = imm_q[k-1];
      ill_d[k]   = ill_q[k-1];
      tag_d[k]   = tag_q[k-1];
    end
  end

  // NOTE: the data registers are reset too, because the outputs must read zero after reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      valid_q <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        imm_q[k] <= '0;
        ill_q[k] <= 1'b0;
        tag_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        if (accept[k]) begin
          valid_q[k] <= valid_d[k];
          // Bubbles leave the data untouched so the outputs hold after a pop.
          if (valid_d[k]) begin
            imm_q[k] <= imm_d[k];
            ill_q[k] <= ill_d[k];
            tag_q[k] <= tag_d[k];
          end
        end
      end
      if (FLUSH) valid_q <= '0;
    end
  end

  assign IN_READY  = RESET && accept[0];
  assign OUT_VALID = valid_q[LAST];
  assign IMMEDIATE = imm_q[LAST];
  assign ILLEGAL   = ill_q[LAST];
  assign OUT_TAG   = tag_q[LAST];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: four configurations share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_imm_gen_pipe;

  localparam int NCFG = 4;

  function automatic int depth_of(int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int xlen_of(int g);
    return (g < 2) ? 32 : 64;
  endfunction

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] ins;
  logic [2:0]  sel;
  logic [31:0] tag;
  logic        out_ready;

  logic        dut_valid [NCFG];
  logic        dut_ready [NCFG];
  logic        dut_ill   [NCFG];
  logic [63:0] dut_imm   [NCFG];
  logic [31:0] dut_tag   [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : gen_dut
    localparam int D = depth_of(g);
    localparam int X = xlen_of(g);
    logic         o_valid, i_ready, o_ill;
    logic [X-1:0] o_imm;
    logic [31:0]  o_tag;

    imm_gen_pipe #(.XLEN(X), .PIPE_DEPTH(D), .TAG_W(32)) u_dut (
      .CLK(clk), .RESET(rst_n), .FLUSH(flush),
      .IN_VALID(in_valid), .IN_READY(i_ready),
      .INSTRUCTION(ins), .IMM_SEL(sel), .IN_TAG(tag),
      .OUT_VALID(o_valid), .OUT_READY(out_ready),
      .IMMEDIATE(o_imm), .ILLEGAL(o_ill), .OUT_TAG(o_tag)
    );

    assign dut_valid[g] = o_valid;
    assign dut_ready[g] = i_ready;
    assign dut_ill[g]   = o_ill;
    assign dut_imm[g]   = 64'(o_imm);
    assign dut_tag[g]   = o_tag;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, int g, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cfg %0d, depth %0d, xlen %0d): got 0x%0h, expected 0x%0h",
               name, g, depth_of(g), xlen_of(g), act, exp);
    end
  endtask

  // Reference immediate: the format's field value as a signed/unsigned number,
  // then truncated to the configured width.
  function automatic logic [63:0] ref_imm(logic [31:0] i, logic [2:0] s, int xlen);
    longint v;
    case (s)
      3'd0:    v = longint'($signed(i[31:20]));
      3'd1:    v = longint'($signed({i[31:25], i[11:7]}));
      3'd2:    v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd3:    v = longint'($signed({i[31:12], 12'h000}));
      3'd4:    v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      3'd5:    v = longint'(i[19:15]);
      3'd6:    v = (xlen == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
      default: v = 0;
    endcase
    return (xlen == 32) ? {32'h0, v[31:0]} : v;
  endfunction

  function automatic logic ref_ill(logic [31:0] i, logic [2:0] s, int xlen);
    return (s == 3'd6) && (xlen == 32) && i[25];
  endfunction

  // Model: an ordered queue of accepted entries. Each entry reaches the output
  // D-1 edges after capture, or on the edge its predecessor leaves, whichever
  // is later.
  typedef struct {
    logic [63:0] imm;
    logic        ill;
    logic [31:0] tag;
    int          arr;
  } ent_t;

  ent_t        q [NCFG][$];
  ent_t        hold [NCFG];
  bit          hold_known [NCFG];
  bit          started = 1'b0;
  int          cyc = 0;

  always @(posedge clk) begin
    int e;
    e = cyc + 1;
    for (int g = 0; g < NCFG; g++) begin
      int   d;
      bit   head_out, rdy;
      ent_t n;
      d = depth_of(g);
      if (!rst_n) begin
        q[g].delete();
        hold[g]       = '{imm: 64'h0, ill: 1'b0, tag: 32'h0, arr: 0};
        hold_known[g] = 1'b1;
      end else if (flush) begin
        q[g].delete();
        hold_known[g] = 1'b0;
      end else begin
        head_out = (q[g].size() > 0) && (q[g][0].arr <= cyc);
        rdy      = out_ready || (q[g].size() < d);
        if (head_out && out_ready) begin
          hold[g]       = q[g][0];
          hold_known[g] = 1'b1;
          void'(q[g].pop_front());
          if (q[g].size() > 0) begin
            n = q[g][0];
            if (n.arr < e) n.arr = e;
            q[g][0] = n;
          end
        end
        if (in_valid && rdy) begin
          n.imm = ref_imm(ins, sel, xlen_of(g));
          n.ill = ref_ill(ins, sel, xlen_of(g));
          n.tag = tag;
          n.arr = e + d - 1;
          q[g].push_back(n);
        end
      end
    end
    if (!rst_n) started = 1'b1;
    cyc = e;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int g = 0; g < NCFG; g++) begin
        bit ev, er;
        ev = (q[g].size() > 0) && (q[g][0].arr <= cyc);
        er = rst_n && (out_ready || (q[g].size() < depth_of(g)));
        check("out_valid", g, 64'(dut_valid[g]), 64'(ev));
        check("in_ready", g, 64'(dut_ready[g]), 64'(er));
        if (ev) begin
          check("immediate", g, dut_imm[g], q[g][0].imm);
          check("illegal", g, 64'(dut_ill[g]), 64'(q[g][0].ill));
          check("out_tag", g, 64'(dut_tag[g]), 64'(q[g][0].tag));
        end else if (hold_known[g]) begin
          check("held_immediate", g, dut_imm[g], hold[g].imm);
          check("held_illegal", g, 64'(dut_ill[g]), 64'(hold[g].ill));
          check("held_tag", g, 64'(dut_tag[g]), 64'(hold[g].tag));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic v, logic [31:0] i, logic [2:0] s, logic [31:0] t);
    in_valid = v;
    ins      = i;
    sel      = s;
    tag      = t;
  endtask

  task automatic drain(int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  // Checks every configuration for a lone entry pushed into an empty pipe.
  task automatic check_latency(string name, logic [31:0] t);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) begin
        check({name, "_valid"}, g, 64'(dut_valid[g]), 64'(n == depth_of(g)));
        if (n == depth_of(g)) check({name, "_tag"}, g, 64'(dut_tag[g]), 64'(t));
      end
      tick();
    end
  endtask

  localparam int NSW = 7;
  logic [31:0] sw_ins   [NSW] = '{32'hFE000EE3, 32'h0080006F, 32'h123450B7, 32'h3400D073,
                                  32'hFFFFFFFF, 32'h01F09093, 32'h02009093};
  logic [2:0]  sw_sel   [NSW] = '{3'd2, 3'd4, 3'd3, 3'd5, 3'd7, 3'd6, 3'd6};
  logic [63:0] sw_exp32 [NSW] = '{64'hFFFF_FFFC, 64'h8, 64'h1234_5000, 64'h1,
                                  64'h0, 64'h1F, 64'h0};
  logic [63:0] sw_exp64 [NSW] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h1234_5000, 64'h1,
                                  64'h0, 64'h1F, 64'h20};
  logic        sw_ill32 [NSW] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [31:0] got [$];
  bit          clear_valid;
  bit          last_acc;

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 32'h0, 3'd0, 32'h0);
    tick(); tick();

    // Reset state while RESET is still low.
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check("reset_valid", g, 64'(dut_valid[g]), 64'h0);
      check("reset_ready", g, 64'(dut_ready[g]), 64'h0);
      check("reset_imm", g, dut_imm[g], 64'h0);
      check("reset_tag", g, 64'(dut_tag[g]), 64'h0);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) check("release_ready", g, 64'(dut_ready[g]), 64'h1);
    tick();

    // I-type all-ones immediate through each depth.
    set_in(1'b1, 32'hFFF00093, 3'd0, 32'h100);
    tick();
    in_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) begin
        check("itype_valid", g, 64'(dut_valid[g]), 64'(n == depth_of(g)));
        if (n == depth_of(g)) begin
          check("itype_imm", g, dut_imm[g],
                (xlen_of(g) == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF);
          check("itype_tag", g, 64'(dut_tag[g]), 64'h100);
        end
      end
      tick();
    end

    // Format sweep streamed back-to-back.
    set_in(1'b1, sw_ins[0], sw_sel[0], 32'h200);
    tick();
    for (int t = 0; t <= NSW; t++) begin
      if (t + 1 < NSW) set_in(1'b1, sw_ins[t+1], sw_sel[t+1], 32'h200 + 32'(t + 1));
      else             in_valid = 1'b0;
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) begin
        int j;
        if (g == 2) continue;
        j = t - (depth_of(g) - 1);
        if (j >= 0 && j < NSW) begin
          check("sweep_valid", g, 64'(dut_valid[g]), 64'h1);
          check("sweep_imm", g, dut_imm[g], (xlen_of(g) == 32) ? sw_exp32[j] : sw_exp64[j]);
          check("sweep_ill", g, 64'(dut_ill[g]), 64'((xlen_of(g) == 32) ? sw_ill32[j] : 1'b0));
          check("sweep_tag", g, 64'(dut_tag[g]), 64'h200 + 64'(j));
        end
      end
      tick();
    end

    // Backpressure on the depth-2 pipe (cfg 1).
    drain(5);
    out_ready = 1'b0;
    set_in(1'b1, 32'h00500093, 3'd0, 32'h300);
    @(negedge clk); check("bp_ready0", 1, 64'(dut_ready[1]), 64'h1); tick();
    set_in(1'b1, 32'h00600093, 3'd0, 32'h301);
    @(negedge clk); check("bp_ready1", 1, 64'(dut_ready[1]), 64'h1); tick();
    set_in(1'b1, 32'h00700093, 3'd0, 32'h302);
    repeat (4) begin
      @(negedge clk);
      check("bp_full_ready", 1, 64'(dut_ready[1]), 64'h0);
      check("bp_stall_valid", 1, 64'(dut_valid[1]), 64'h1);
      check("bp_stall_imm", 1, dut_imm[1], 64'h5);
      check("bp_stall_tag", 1, 64'(dut_tag[1]), 64'h300);
      tick();
    end
    out_ready = 1'b1;
    got.delete();
    repeat (8) begin
      @(negedge clk);
      if (dut_valid[1] && out_ready) got.push_back(dut_tag[1]);
      clear_valid = in_valid && dut_ready[1];
      tick();
      if (clear_valid) in_valid = 1'b0;
    end
    check("bp_count", 1, 64'(got.size()), 64'h3);
    for (int i = 0; i < got.size() && i < 3; i++)
      check("bp_order", 1, 64'(got[i]), 64'h300 + 64'(i));

    // Flush with a new entry presented on the same edge.
    drain(5);
    for (int t = 0; t < 4; t++) begin
      set_in(1'b1, 32'h00100093 + (32'(t) << 20), 3'd0, 32'h400 + 32'(t));
      tick();
    end
    flush = 1'b1;
    set_in(1'b1, 32'h00900093, 3'd0, 32'h4FF);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check("flush_valid", g, 64'(dut_valid[g]), 64'h0);
      check("flush_ready", g, 64'(dut_ready[g]), 64'h1);
    end
    tick();
    set_in(1'b1, 32'h00A00093, 3'd0, 32'h500);
    tick();
    in_valid = 1'b0;
    check_latency("post_flush", 32'h500);

    // Reset with full pipes.
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      set_in(1'b1, 32'hABC00093, 3'd0, 32'h600 + 32'(t));
      tick();
    end
    rst_n = 1'b0;
    set_in(1'b1, 32'hABC00093, 3'd0, 32'h6FF);
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) check("rst_low_ready", g, 64'(dut_ready[g]), 64'h0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check("midrst_valid", g, 64'(dut_valid[g]), 64'h0);
      check("midrst_imm", g, dut_imm[g], 64'h0);
      check("midrst_ill", g, 64'(dut_ill[g]), 64'h0);
      check("midrst_tag", g, 64'(dut_tag[g]), 64'h0);
      check("midrst_ready", g, 64'(dut_ready[g]), 64'h1);
    end
    tick();
    set_in(1'b1, 32'h02009093, 3'd6, 32'h700);
    tick();
    in_valid = 1'b0;
    check_latency("post_reset", 32'h700);

    // Randomized traffic; the producer holds an entry until cfg 1 accepts it.
    last_acc = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || last_acc)
        set_in(($urandom % 4) != 0, $urandom, 3'($urandom_range(0, 7)), $urandom);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 64) == 0;
      rst_n     = ($urandom % 256) != 0;
      @(negedge clk);
      last_acc = in_valid && dut_ready[1];
      tick();
    end
    flush = 1'b0;
    rst_n = 1'b1;
    drain(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage of the RV32IM pipeline (extendable to RV64).
- Extracts and sign/zero-extends immediates for the I/S/B/U/J formats, the CSR zimm and the shift amount.
- Flags illegal shift amounts.
- Carries a sideband tag (PC/rd) through PIPE_DEPTH register stages with a valid/ready handshake and flush.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- PIPE_DEPTH, 1, number of register stages between input and output; legal range 1..3.
- TAG_W, 32, width of the pass-through sideband tag.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-low reset.
- FLUSH  input  1  kill all in-flight entries (branch mispredict / trap).
- IN_VALID  input  1  input entry valid.
- IN_READY  output  1  block can accept an input this cycle.
- INSTRUCTION  input  32  raw instruction word.
- IMM_SEL  input  3  format select.
- IN_TAG  input  TAG_W  sideband carried alongside the instruction.
- OUT_VALID  output  1  output entry valid.
- OUT_READY  input  1  consumer accepts the output this cycle.
- IMMEDIATE  output  XLEN  generated immediate.
- ILLEGAL  output  1  illegal-encoding flag for the output entry.
- OUT_TAG  output  TAG_W  tag of the output entry.

Behaviour:
- IMM_SEL encoding (S = INSTRUCTION[31] replicated to XLEN):
  - 000 I: S, [30:20]
  - 001 S: S, [30:25], [11:7]
  - 010 B: S, [7], [30:25], [11:8], 0
  - 011 U: S above bit 31, [31:12], 12'b0
  - 100 J: S, [19:12], [20], [30:21], 0
  - 101 Z: zero-extended [19:15]
  - 110 SHAMT: zero-extended [24:20] if XLEN=32, [25:20] if XLEN=64
  - 111: all zero
- ILLEGAL = 1 only when IMM_SEL=110, XLEN=32 and INSTRUCTION[25]=1; otherwise 0.
- Immediate computation is combinational into stage 0. Each stage k holds valid_k, imm_k, illegal_k and tag_k. The last stage drives the outputs.
- Stage advance:
  - stage k accepts when !valid_k or stage k is emptying.
  - The last stage empties on OUT_VALID && OUT_READY.
  - IN_READY = stage-0 accept condition. IN_READY may depend combinationally on OUT_READY; no combinational path from IN_VALID to OUT_VALID.
- Input capture on a rising edge requires IN_VALID && IN_READY. IN_VALID with IN_READY=0 is ignored; the producer holds its data.
- Latency is exactly PIPE_DEPTH cycles with OUT_READY held high. Throughput is 1 entry/cycle. Order is strictly FIFO.
- Stall: with OUT_READY=0 the output holds IMMEDIATE/ILLEGAL/OUT_TAG stable while OUT_VALID=1. Upstream stages keep filling bubbles.
  - Full condition: all PIPE_DEPTH stages valid and OUT_READY=0, so IN_READY=0.
- Simultaneous output pop and input push while full: both occur and the entry count is unchanged (no bubble).
- FLUSH=1 at an edge:
  - All valid bits clear, overriding any capture that edge; the entry presented with FLUSH is discarded.
  - Data registers are don't-care.
  - The next cycle shows OUT_VALID=0 and IN_READY=1.
- Priority at an edge: RESET low > FLUSH > normal advance.
- Reset (RESET low at an edge), including mid-stream:
  - All valid bits cleared.
  - IMMEDIATE=0, ILLEGAL=0, OUT_TAG=0, OUT_VALID=0.
  - IN_READY=0 while RESET is low, then 1 on the first cycle after release.
- Outputs are held (not zeroed) when OUT_VALID=0 after an entry leaves; the consumer must qualify on OUT_VALID.

Test Plan:
- I-type, PIPE_DEPTH=1/2/3, OUT_READY=1: 0xFFF00093, SEL=000, TAG=0x100 → IMMEDIATE=0xFFFFFFFF, OUT_TAG=0x100 exactly PIPE_DEPTH cycles later; XLEN=64 → 0xFFFFFFFFFFFFFFFF.
- Format sweep streamed back-to-back, one entry/cycle:
  - 0xFE000EE3/B → 0xFFFFFFFC
  - 0x0080006F/J → 0x00000008
  - 0x123450B7/U → 0x12345000
  - 0x3400D073/Z → 0x00000001
  - SEL=111 → 0
  - Outputs emerge in order on consecutive cycles.
- Shift: 0x01F09093/SHAMT → 0x1F with ILLEGAL=0; 0x02009093 → ILLEGAL=1 when XLEN=32, ILLEGAL=0 with IMMEDIATE=0x20 when XLEN=64.
- Backpressure, PIPE_DEPTH=2: push 3 entries with OUT_READY=0 → IN_READY=0 after 2 entries are accepted and output stable. Release → all 3 entries delivered in order, with no loss or duplication.
- Flush: stream 4 entries, assert FLUSH for 1 cycle with IN_VALID=1 → next cycle OUT_VALID=0. No flushed tag ever appears; the next new entry appears after PIPE_DEPTH cycles.
- Reset mid-stream: RESET low for 1 cycle with a full pipe → OUT_VALID=0, IMMEDIATE=0, ILLEGAL=0, OUT_TAG=0. After release, normal operation resumes with no stale entries.
